// File: rtl/piece_motion_ctrl.sv
// Active-tetromino motion controller: spawns the piece, applies gravity and soft drop,
// applies edge-triggered left/right/rotate keys and locks the piece on touchdown.
module piece_motion_ctrl #(
  parameter int          GRAVITY_FRAMES = 30,
  parameter int          BOARD_W        = 10,
  parameter int          BOARD_H        = 20,
  parameter int          SPAWN_X        = 4,
  parameter logic [15:0] KEY_LEFT       = 16'h0004,
  parameter logic [15:0] KEY_RIGHT      = 16'h0007,
  parameter logic [15:0] KEY_ROT        = 16'h001A,
  parameter logic [15:0] KEY_DROP       = 16'h0016
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_tick,
  input  logic [15:0] keycode,
  input  logic [2:0]  shape_num,
  input  logic        touchdown,
  input  logic        blocked_left,
  input  logic        blocked_right,
  input  logic        blocked_rot,
  output logic [2:0]  piece_shape,
  output logic [1:0]  piece_rot,
  output logic [3:0]  piece_x,
  output logic [4:0]  piece_y,
  output logic        spawn_pulse,
  output logic        lock_pulse
);

  localparam int             GRAV_W   = $clog2(GRAVITY_FRAMES);
  localparam logic [GRAV_W-1:0] GRAV_MAX = GRAV_W'(GRAVITY_FRAMES - 1);
  localparam logic [3:0]     X_MAX    = 4'(BOARD_W - 1);
  localparam logic [4:0]     Y_MAX    = 5'(BOARD_H - 1);
  localparam logic [3:0]     X_SPAWN  = 4'(SPAWN_X);

  typedef enum logic [1:0] {ST_SPAWN, ST_FALL, ST_LOCK} state_t;

  state_t            state_q, state_d;
  logic [2:0]        shape_q, shape_d;
  logic [1:0]        rot_q, rot_d;
  logic [3:0]        x_q, x_d;
  logic [4:0]        y_q, y_d;
  logic [GRAV_W-1:0] grav_cnt_q, grav_cnt_d;
  logic              key_armed_q, key_armed_d;
  logic              spawn_pulse_q, spawn_pulse_d;
  logic              lock_pulse_q, lock_pulse_d;
  logic              step_due;
  logic              key_hit;

  always_comb begin
    state_d       = state_q;
    shape_d       = shape_q;
    rot_d         = rot_q;
    x_d           = x_q;
    y_d           = y_q;
    grav_cnt_d    = grav_cnt_q;
    key_armed_d   = key_armed_q;
    spawn_pulse_d = 1'b0;
    lock_pulse_d  = 1'b0;
    step_due      = 1'b0;
    key_hit       = (keycode == KEY_LEFT) || (keycode == KEY_RIGHT) || (keycode == KEY_ROT);

    // Re-arming happens on any idle keyboard cycle, whatever the state.
    if (keycode == 16'h0000) key_armed_d = 1'b1;

    case (state_q)
      ST_SPAWN: begin
        shape_d       = (shape_num == 3'd0) ? 3'd1 : shape_num;
        rot_d         = 2'd0;
        x_d           = X_SPAWN;
        y_d           = 5'd0;
        grav_cnt_d    = '0;
        spawn_pulse_d = 1'b1;
        state_d       = ST_FALL;
      end
      ST_FALL: begin
        if (frame_tick) begin
          step_due = (grav_cnt_q == GRAV_MAX) || (keycode == KEY_DROP);
          if (!step_due) begin
            grav_cnt_d = grav_cnt_q + 1'b1;
          end else if (touchdown || (y_q == Y_MAX)) begin
            state_d = ST_LOCK;
          end else begin
            y_d        = y_q + 5'd1;
            grav_cnt_d = '0;
          end
        end else if (key_armed_q && key_hit) begin
          // Blocked or out-of-range actions are consumed without effect.
          key_armed_d = 1'b0;
          if (keycode == KEY_LEFT) begin
            if (!blocked_left && (x_q != 4'd0)) x_d = x_q - 4'd1;
          end else if (keycode == KEY_RIGHT) begin
            if (!blocked_right && (x_q < X_MAX)) x_d = x_q + 4'd1;
          end else begin
            if (!blocked_rot) rot_d = rot_q + 2'd1;
          end
        end
      end
      ST_LOCK: begin
        lock_pulse_d = 1'b1;
        state_d      = ST_SPAWN;
      end
      default: state_d = ST_SPAWN;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q       <= ST_SPAWN;
      shape_q       <= 3'd0;
      rot_q         <= 2'd0;
      x_q           <= X_SPAWN;
      y_q           <= 5'd0;
      grav_cnt_q    <= '0;
      key_armed_q   <= 1'b1;
      spawn_pulse_q <= 1'b0;
      lock_pulse_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      shape_q       <= shape_d;
      rot_q         <= rot_d;
      x_q           <= x_d;
      y_q           <= y_d;
      grav_cnt_q    <= grav_cnt_d;
      key_armed_q   <= key_armed_d;
      spawn_pulse_q <= spawn_pulse_d;
      lock_pulse_q  <= lock_pulse_d;
    end
  end

  assign piece_shape = shape_q;
  assign piece_rot   = rot_q;
  assign piece_x     = x_q;
  assign piece_y     = y_q;
  assign spawn_pulse = spawn_pulse_q;
  assign lock_pulse  = lock_pulse_q;

endmodule

// File: tb/tb_piece_motion_ctrl.sv
// Scoreboard bench for piece_motion_ctrl: stimulus queues each expected output event just
// before causing it; the monitor pops one entry per observed pulse or descriptor change.
module tb_piece_motion_ctrl;

  localparam logic [15:0] K_LEFT  = 16'h0004;
  localparam logic [15:0] K_RIGHT = 16'h0007;
  localparam logic [15:0] K_ROT   = 16'h001A;
  localparam logic [15:0] K_DROP  = 16'h0016;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        frame_tick;
  logic [15:0] keycode;
  logic [2:0]  shape_num;
  logic        touchdown, blocked_left, blocked_right, blocked_rot;
  logic [2:0]  piece_shape;
  logic [1:0]  piece_rot;
  logic [3:0]  piece_x;
  logic [4:0]  piece_y;
  logic        spawn_pulse, lock_pulse;

  int n_chk  = 0;
  int n_pass = 0;

  // Event word: {spawn_pulse, lock_pulse, shape[2:0], rot[1:0], x[3:0], y[4:0]}
  logic [15:0] exp_q[$];

  piece_motion_ctrl dut (
    .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .keycode(keycode),
    .shape_num(shape_num), .touchdown(touchdown), .blocked_left(blocked_left),
    .blocked_right(blocked_right), .blocked_rot(blocked_rot),
    .piece_shape(piece_shape), .piece_rot(piece_rot), .piece_x(piece_x),
    .piece_y(piece_y), .spawn_pulse(spawn_pulse), .lock_pulse(lock_pulse)
  );

  always #5 Clk = ~Clk;

  function automatic logic [15:0] ev(input logic sp, input logic lk, input logic [2:0] sh,
                                     input logic [1:0] r, input logic [3:0] x, input logic [4:0] y);
    return {sp, lk, sh, r, x, y};
  endfunction

  task automatic push(input logic [15:0] e);
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, got, want);
  endtask

  task automatic cyc(input logic ft);
    frame_tick = ft;
    @(posedge Clk);
    #1;
    frame_tick = 1'b0;
  endtask

  task automatic press(input logic [15:0] k);
    keycode = k;
    cyc(1'b0);
    cyc(1'b0);
    keycode = 16'h0000;
    cyc(1'b0);
  endtask

  // Monitor
  initial begin
    logic [13:0] prev, cur;
    logic [15:0] obs, want;
    prev = '0;
    forever begin
      @(negedge Clk);
      cur = {piece_shape, piece_rot, piece_x, piece_y};
      if (Reset !== 1'b0) begin
        prev = cur;
      end else begin
        if (spawn_pulse || lock_pulse || (cur != prev)) begin
          obs = {spawn_pulse, lock_pulse, cur};
          n_chk++;
          if (exp_q.size() == 0) begin
            $display("FAIL unexpected_event: got %h, expected no event", obs);
          end else begin
            want = exp_q.pop_front();
            if (obs === want) n_pass++;
            else $display("FAIL event: got %h, expected %h", obs, want);
          end
        end
        prev = cur;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1; frame_tick = 1'b0; keycode = 16'h0000; shape_num = 3'd3;
    touchdown = 1'b0; blocked_left = 1'b0; blocked_right = 1'b0; blocked_rot = 1'b0;
    repeat (3) cyc(1'b0);
    chk("reset_desc", {2'b00, piece_shape, piece_rot, piece_x, piece_y}, ev(0, 0, 3'd0, 2'd0, 4'd4, 5'd0));
    chk("reset_pulses", {14'd0, spawn_pulse, lock_pulse}, 16'd0);

    // Spawn shape 3
    push(ev(1, 0, 3'd3, 2'd0, 4'd4, 5'd0));
    Reset = 1'b0;
    repeat (3) cyc(1'b0);

    // Gravity: one row per 30 frame ticks
    for (int i = 1; i <= 60; i++) begin
      if (i == 30) push(ev(0, 0, 3'd3, 2'd0, 4'd4, 5'd1));
      if (i == 60) push(ev(0, 0, 3'd3, 2'd0, 4'd4, 5'd2));
      cyc(1'b1);
      cyc(1'b0);
    end

    // Held left: no action in the tick cycle, then exactly one move per press
    keycode = K_LEFT;
    cyc(1'b1);
    push(ev(0, 0, 3'd3, 2'd0, 4'd3, 5'd2));
    repeat (99) cyc(1'b0);
    keycode = 16'h0000;
    cyc(1'b0);
    push(ev(0, 0, 3'd3, 2'd0, 4'd2, 5'd2));
    keycode = K_LEFT;
    repeat (10) cyc(1'b0);
    keycode = 16'h0000;
    cyc(1'b0);

    // Unrelated keycode neither acts nor re-arms
    push(ev(0, 0, 3'd3, 2'd0, 4'd1, 5'd2));
    keycode = K_LEFT;  repeat (2) cyc(1'b0);
    keycode = 16'h0010; repeat (2) cyc(1'b0);
    keycode = K_LEFT;  repeat (2) cyc(1'b0);
    keycode = 16'h0000; cyc(1'b0);

    // Left edge of the board
    push(ev(0, 0, 3'd3, 2'd0, 4'd0, 5'd2));
    press(K_LEFT);
    press(K_LEFT);

    // Rotation wraps, blocked rotation discarded
    for (int r = 1; r <= 5; r++) begin
      push(ev(0, 0, 3'd3, 2'(r % 4), 4'd0, 5'd2));
      press(K_ROT);
    end
    blocked_rot = 1'b1;
    press(K_ROT);
    blocked_rot = 1'b0;

    // Right saturates at column 9
    for (int p = 1; p <= 11; p++) begin
      if (p <= 9) push(ev(0, 0, 3'd3, 2'd1, 4'(p), 5'd2));
      press(K_RIGHT);
    end
    blocked_left = 1'b1;
    press(K_LEFT);
    blocked_left = 1'b0;
    push(ev(0, 0, 3'd3, 2'd1, 4'd8, 5'd2));
    press(K_LEFT);
    blocked_right = 1'b1;
    press(K_RIGHT);
    blocked_right = 1'b0;

    // Soft drop to y=5, touchdown lock, respawn shape 5
    keycode = K_DROP;
    for (int y = 3; y <= 5; y++) begin
      push(ev(0, 0, 3'd3, 2'd1, 4'd8, 5'(y)));
      cyc(1'b1);
      cyc(1'b0);
    end
    touchdown = 1'b1;
    shape_num = 3'd5;
    push(ev(0, 1, 3'd3, 2'd1, 4'd8, 5'd5));
    push(ev(1, 0, 3'd5, 2'd0, 4'd4, 5'd0));
    cyc(1'b1);
    touchdown = 1'b0;
    keycode = 16'h0000;
    repeat (4) cyc(1'b0);

    // Soft drop to the floor, lock at bottom row, shape_num 0 spawns shape 1
    shape_num = 3'd0;
    keycode = K_DROP;
    for (int y = 1; y <= 19; y++) begin
      push(ev(0, 0, 3'd5, 2'd0, 4'd4, 5'(y)));
      cyc(1'b1);
      cyc(1'b0);
    end
    push(ev(0, 1, 3'd5, 2'd0, 4'd4, 5'd19));
    push(ev(1, 0, 3'd1, 2'd0, 4'd4, 5'd0));
    cyc(1'b1);
    keycode = 16'h0000;
    repeat (4) cyc(1'b0);

    // Reset mid-fall
    keycode = K_DROP;
    for (int y = 1; y <= 2; y++) begin
      push(ev(0, 0, 3'd1, 2'd0, 4'd4, 5'(y)));
      cyc(1'b1);
      cyc(1'b0);
    end
    keycode = 16'h0000;
    cyc(1'b0);
    Reset = 1'b1;
    #1;
    chk("async_reset_desc", {2'b00, piece_shape, piece_rot, piece_x, piece_y}, ev(0, 0, 3'd0, 2'd0, 4'd4, 5'd0));
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0);
      chk("reset_no_pulse", {14'd0, spawn_pulse, lock_pulse}, 16'd0);
    end
    shape_num = 3'd6;
    push(ev(1, 0, 3'd6, 2'd0, 4'd4, 5'd0));
    Reset = 1'b0;
    repeat (4) cyc(1'b0);

    chk("events_outstanding", 16'(exp_q.size()), 16'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
